rvfi_dii_insn_injector: RTL and testbench

Instruction source for RVFI-DII (Direct Instruction Injection) builds. The block buffers instructions streamed by the DII host and presents them to the frontend fetch interface in place of the I-cache. It keeps every issued-but-uncommitted instruction so that it can replay from the commit point after a pipeline flush. It is instantiated only when the core configuration enables RVFI_DII, and sits directly upstream of the frontend instruction queue.

---
 rtl/rvfi_dii_insn_injector.sv | 149 ++++++++++++++
 tb/tb_rvfi_dii_insn_injector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_dii_insn_injector.sv
// RVFI-DII instruction injector: buffers host-streamed instructions, feeds
// the frontend, and replays from the oldest uncommitted entry on flush.
module rvfi_dii_insn_injector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned IDW   = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            dii_valid_i,
    output logic            dii_ready_o,
    input  logic            dii_cmd_i,
    input  logic [ILEN-1:0] dii_insn_i,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    output logic [ILEN-1:0] fetch_insn_o,
    output logic [IDW-1:0]  fetch_id_o,
    input  logic            commit_i,
    input  logic            flush_i,
    output logic            trace_done_o,
    output logic            err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_CLEAR
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   cm_q, cm_d;
    logic [IDW-1:0]  seq_q, seq_d;
    logic            err_q, err_d;
    logic [ILEN-1:0] insn_q [DEPTH];
    logic [ILEN-1:0] insn_d [DEPTH];
    logic [IDW-1:0]  id_q [DEPTH];
    logic [IDW-1:0]  id_d [DEPTH];

    logic full;
    logic has_issue;
    logic has_commit;
    logic accept;
    logic wr_en;
    logic issue;
    logic commit_ok;
    logic in_clear;

    // Pointers carry a wrap bit, so full and empty are distinguishable.
    assign full       = (wr_q - cm_q) == PW'(DEPTH);
    assign has_issue  = rd_q != wr_q;
    assign has_commit = cm_q != rd_q;
    assign in_clear   = state_q == S_CLEAR;

    assign dii_ready_o   = (state_q == S_RUN) && !full;
    assign fetch_valid_o = has_issue && !flush_i && !in_clear;

    assign accept    = dii_valid_i && dii_ready_o;
    assign wr_en     = accept && dii_cmd_i;
    assign issue     = fetch_valid_o && fetch_ready_i;
    assign commit_ok = commit_i && has_commit && !in_clear;

    assign fetch_insn_o = insn_q[rd_q[AW-1:0]];
    assign fetch_id_o   = id_q[rd_q[AW-1:0]];
    assign trace_done_o = in_clear;
    assign err_o        = err_q;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cm_d    = cm_q;
        seq_d   = seq_q;
        insn_d  = insn_q;
        id_d    = id_q;
        err_d   = err_q
                | (commit_i && !commit_ok)
                | (flush_i && in_clear);

        if (commit_ok) begin
            cm_d = cm_q + PW'(1);
        end
        if (issue) begin
            rd_d = rd_q + PW'(1);
        end
        // Replay restarts at the commit point including this cycle's commit.
        if (flush_i) begin
            rd_d = cm_d;
        end
        if (wr_en) begin
            insn_d[wr_q[AW-1:0]] = dii_insn_i;
            id_d[wr_q[AW-1:0]]   = seq_q;
            wr_d                 = wr_q + PW'(1);
            seq_d                = seq_q + IDW'(1);
        end

        unique case (state_q)
            S_RUN: begin
                if (accept && !dii_cmd_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((cm_q == wr_q) && !commit_i) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
                wr_d    = '0;
                rd_d    = '0;
                cm_d    = '0;
                seq_d   = '0;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RUN;
            wr_q    <= '0;
            rd_q    <= '0;
            cm_q    <= '0;
            seq_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                insn_q[i] <= '0;
                id_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cm_q    <= cm_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
            insn_q  <= insn_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_rvfi_dii_insn_injector.sv
// Randomized bench for rvfi_dii_insn_injector against a queue-based model
// of uncommitted entries, plus directed scenarios with literal expectations.
module tb_rvfi_dii_insn_injector;

    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        dii_valid_i;
    logic        dii_ready_o;
    logic        dii_cmd_i;
    logic [31:0] dii_insn_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_insn_o;
    logic [15:0] fetch_id_o;
    logic        commit_i;
    logic        flush_i;
    logic        trace_done_o;
    logic        err_o;

    rvfi_dii_insn_injector #(.DEPTH(DEPTH), .ILEN(32), .IDW(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .dii_valid_i  (dii_valid_i),
        .dii_ready_o  (dii_ready_o),
        .dii_cmd_i    (dii_cmd_i),
        .dii_insn_i   (dii_insn_i),
        .fetch_valid_o(fetch_valid_o),
        .fetch_ready_i(fetch_ready_i),
        .fetch_insn_o (fetch_insn_o),
        .fetch_id_o   (fetch_id_o),
        .commit_i     (commit_i),
        .flush_i      (flush_i),
        .trace_done_o (trace_done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] insn;
        logic [15:0] id;
    } ent_t;

    // Model: pending entries oldest first; the first m_iss are issued.
    ent_t pend[$];
    int   m_iss;
    int   m_seq;
    bit   m_drain;
    bit   m_clear;
    bit   m_err;

    int ncmp  = 0;
    int nfail = 0;
    int pulses;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_iss   = 0;
        m_seq   = 0;
        m_drain = 0;
        m_clear = 0;
        m_err   = 0;
    endtask

    task automatic idle_inputs();
        dii_valid_i   = 1'b0;
        dii_cmd_i     = 1'b0;
        dii_insn_i    = '0;
        fetch_ready_i = 1'b0;
        commit_i      = 1'b0;
        flush_i       = 1'b0;
    endtask

    // Drive one cycle, check outputs against the model, advance the model.
    task automatic step(input bit v, input bit c, input logic [31:0] w,
                        input bit fr, input bit cm, input bit fl);
        bit   rdy_e, val_e, acc, iss, legal, go_clear;
        ent_t e;
        dii_valid_i   = v;
        dii_cmd_i     = c;
        dii_insn_i    = w;
        fetch_ready_i = fr;
        commit_i      = cm;
        flush_i       = fl;
        #2;
        rdy_e = !m_drain && !m_clear && pend.size() < DEPTH;
        val_e = m_iss < pend.size() && !fl && !m_clear;
        chk("ready", 32'(dii_ready_o), 32'(rdy_e));
        chk("valid", 32'(fetch_valid_o), 32'(val_e));
        chk("done", 32'(trace_done_o), 32'(m_clear));
        chk("err", 32'(err_o), 32'(m_err));
        if (val_e) begin
            chk("insn", fetch_insn_o, pend[m_iss].insn);
            chk("id", 32'(fetch_id_o), 32'(pend[m_iss].id));
        end
        acc   = v && rdy_e;
        iss   = val_e && fr;
        legal = cm && !m_clear && m_iss > 0;
        if ((cm && !legal) || (fl && m_clear)) m_err = 1;
        if (m_clear) begin
            pend.delete();
            m_iss   = 0;
            m_seq   = 0;
            m_clear = 0;
        end else begin
            go_clear = m_drain && pend.size() == 0 && !cm;
            if (legal) begin
                void'(pend.pop_front());
                m_iss--;
            end
            if (iss) m_iss++;
            if (fl) m_iss = 0;
            if (acc) begin
                if (c) begin
                    e.insn = w;
                    e.id   = m_seq[15:0];
                    pend.push_back(e);
                    m_seq = (m_seq + 1) % 65536;
                end else begin
                    m_drain = 1;
                end
            end
            if (go_clear) begin
                m_drain = 0;
                m_clear = 1;
            end
        end
        @(posedge clk_i);
        #1;
        idle_inputs();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        bit v, c, fr, cm, fl;
        idle_inputs();
        model_reset();
        rst_ni = 1'b0;
        #3;
        chk("rst_ready", 32'(dii_ready_o), 32'd1);
        chk("rst_valid", 32'(fetch_valid_o), 32'd0);
        chk("rst_insn", fetch_insn_o, 32'd0);
        chk("rst_id", 32'(fetch_id_o), 32'd0);
        chk("rst_done", 32'(trace_done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;

        // Stream of three instructions, one per cycle.
        step(1, 1, 32'h0000_0013, 1, 0, 0);
        chk("s_valid0", 32'(fetch_valid_o), 32'd1);
        chk("s_id0", 32'(fetch_id_o), 32'd0);
        chk("s_insn0", fetch_insn_o, 32'h0000_0013);
        step(1, 1, 32'h0010_0093, 1, 0, 0);
        chk("s_id1", 32'(fetch_id_o), 32'd1);
        chk("s_insn1", fetch_insn_o, 32'h0010_0093);
        step(1, 1, 32'h0020_0113, 1, 0, 0);
        chk("s_id2", 32'(fetch_id_o), 32'd2);
        chk("s_insn2", fetch_insn_o, 32'h0020_0113);
        step(0, 0, 0, 1, 0, 0);
        chk("s_empty", 32'(fetch_valid_o), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);

        // End of trace: two instructions, end command, two commits.
        step(1, 1, 32'h0000_1111, 1, 0, 0);
        step(1, 1, 32'h0000_2222, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        chk("drain_ready", 32'(dii_ready_o), 32'd0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (trace_done_o === 1'b1) pulses++;
        end
        chk("done_pulses", 32'(pulses), 32'd1);
        step(1, 1, 32'h0000_3333, 0, 0, 0);
        chk("eot_id0", 32'(fetch_id_o), 32'd0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);

        // Fill to capacity without commits.
        for (int i = 0; i < DEPTH; i++) step(1, 1, 32'h200 + 32'(i), 0, 0, 0);
        chk("full_ready", 32'(dii_ready_o), 32'd0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 1, 32'hdead_beef, 0, 1, 0);
        chk("unfull_ready", 32'(dii_ready_o), 32'd1);

        // Reset mid-stream drops everything at once.
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 32'(fetch_valid_o), 32'd0);
        chk("arst_ready", 32'(dii_ready_o), 32'd1);
        do_reset();

        // Flush replay from id 2.
        for (int i = 0; i < 5; i++) step(1, 1, 32'h100 + 32'(i), 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("fl_id2", 32'(fetch_id_o), 32'd2);
        chk("fl_insn2", fetch_insn_o, 32'h102);
        step(0, 0, 0, 1, 0, 0);
        chk("fl_id3", 32'(fetch_id_o), 32'd3);
        step(0, 0, 0, 1, 0, 0);
        chk("fl_id4", 32'(fetch_id_o), 32'd4);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);

        // Commit and flush together.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 32'h300 + 32'(i), 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("cf_valid", 32'(fetch_valid_o), 32'd1);
        chk("cf_id1", 32'(fetch_id_o), 32'd1);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            v  = $urandom_range(0, 3) != 0;
            c  = $urandom_range(0, 59) != 0;
            fr = $urandom_range(0, 2) != 0;
            cm = (m_iss > 0) && ($urandom_range(0, 2) == 0);
            fl = !m_clear && ($urandom_range(0, 19) == 0);
            step(v, c, $urandom, fr, cm, fl);
        end

        // Illegal commit is sticky until reset.
        do_reset();
        step(0, 0, 0, 0, 1, 0);
        chk("ill_err", 32'(err_o), 32'd1);
        for (int i = 0; i < 5; i++) step(1, 1, 32'h400 + 32'(i), 1, 0, 0);
        chk("ill_sticky", 32'(err_o), 32'd1);
        do_reset();
        chk("ill_clr", 32'(err_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
